// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS register file slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;

    typedef logic [DEF_ADDR_WIDTH-1:0] reg_idx_t;
    typedef logic [DEF_DATA_WIDTH-1:0] word_t;

    // Hard-wired zero register; never stored, never tracked as pending.
    localparam reg_idx_t REG_ZERO = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, raises stall on read-after-write hazards.
// Latency: stall is combinational; pending bits update on the rising clk edge.
// Backpressure: stall holds decode; nothing is marked pending while stall is high.
// Optional macro REGFILE_BYPASS_EN: a register written this cycle does not cause a stall.
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic                  rt_used,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  stall
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic                rs_byp;
    logic                rt_byp;
    logic                rs_hit;
    logic                rt_hit;

    // Hazard detection: a source hits when its producer has not yet written back.
    always_comb begin
        rs_byp = 1'b0;
        rt_byp = 1'b0;
`ifdef REGFILE_BYPASS_EN
        // The value arriving this cycle is forwarded, so that register is safe to read.
        rs_byp = wr_en && (wr_addr == rs_addr);
        rt_byp = wr_en && (wr_addr == rt_addr);
`endif
        rs_hit = (rs_addr != ZERO_IDX) && pending[rs_addr] && !rs_byp;
        rt_hit = (rt_addr != ZERO_IDX) && pending[rt_addr] && !rt_byp;
        stall  = issue_valid && (rs_hit || (rt_used && rt_hit));
    end

    // Next pending state: clear on write-back first, then set on issue so a newer producer wins.
    always_comb begin
        pending_nxt = pending;
        if (wr_en && (wr_addr != ZERO_IDX)) begin
            pending_nxt[wr_addr] = 1'b0;
        end
        if (issue_valid && !stall && (issue_dest != ZERO_IDX)) begin
            pending_nxt[issue_dest] = 1'b1;
        end
    end

    // Pending bit register; async reset clears all outstanding producers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

endmodule

// File: rtl/mips_register_file.sv
// 32-entry MIPS register file: two combinational read ports, one clocked write port, hazard stall.
// Latency: reads zero-cycle; writes visible next cycle (same cycle with REGFILE_BYPASS_EN).
// Backpressure: stall tells decode to hold when a source register is still pending.
// Optional macro REGFILE_BYPASS_EN: write-through forwarding from the write port to the read ports.
module mips_register_file
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic [DATA_WIDTH-1:0] rs_data,
    output logic [DATA_WIDTH-1:0] rt_data,
    input  logic                  rt_used,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    output logic                  stall,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_live;

    assign wr_live = wr_en && (wr_addr != ZERO_IDX);

    // Storage update; index 0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Read muxing: register 0 reads as zero regardless of storage contents.
    always_comb begin
        rs_data = (rs_addr == ZERO_IDX) ? '0 : regs[rs_addr];
        rt_data = (rt_addr == ZERO_IDX) ? '0 : regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
        // Forward the in-flight write so decode sees it in the same cycle.
        if (wr_live && (wr_addr == rs_addr)) begin
            rs_data = wr_data;
        end
        if (wr_live && (wr_addr == rt_addr)) begin
            rt_data = wr_data;
        end
`endif
    end

    regfile_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rt_used     (rt_used),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .stall       (stall)
    );

endmodule

// File: tb/tb_mips_register_file.sv
// Directed bench for mips_register_file: reads, writes, register zero, scoreboard stalls, async reset.
// Latency: inputs driven 1ns after the rising edge, outputs sampled before the next edge.
// Backpressure: stall expectations computed by hand per vector.
module tb_mips_register_file;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rt_used;
    logic        issue_valid;
    logic [4:0]  issue_dest;
    logic        stall;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;

    int checks   = 0;
    int failures = 0;

    mips_register_file dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .rt_used     (rt_used),
        .issue_valid (issue_valid),
        .issue_dest  (issue_dest),
        .stall       (stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n       = 1'b0;
        rs_addr     = '0;
        rt_addr     = '0;
        rt_used     = 1'b0;
        issue_valid = 1'b0;
        issue_dest  = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        #12;
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_rs0", rs_data, 32'd0);
        #5 rst_n = 1'b1;
        tick();

        // 1: every index reads zero after reset, no stall with nothing pending
        issue_valid = 1'b1;
        issue_dest  = 5'd0;
        rt_used     = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            check("rst_rs_data", rs_data, 32'd0);
            check("rst_rt_data", rt_data, 32'd0);
            check("rst_stall", {31'd0, stall}, 32'd0);
        end
        issue_valid = 1'b0;
        rt_used     = 1'b0;
        tick();

        // 2: write reg 8, visible next cycle on both ports
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'hDEADBEEF;
        tick();
        wr_en   = 1'b0;
        rs_addr = 5'd8;
        rt_addr = 5'd8;
        #1;
        check("wr8_rs", rs_data, 32'hDEADBEEF);
        check("wr8_rt", rt_data, 32'hDEADBEEF);

        // 3: writes to reg 0 are dropped; dest 0 never creates a hazard
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h12345678;
        tick();
        wr_en       = 1'b0;
        rs_addr     = 5'd0;
        rt_addr     = 5'd0;
        rt_used     = 1'b1;
        issue_valid = 1'b1;
        issue_dest  = 5'd0;
        #1;
        check("r0_rs", rs_data, 32'd0);
        check("r0_rt", rt_data, 32'd0);
        check("r0_stall_a", {31'd0, stall}, 32'd0);
        tick();
        check("r0_stall_b", {31'd0, stall}, 32'd0);

        // 4: RAW hazard on reg 5
        rs_addr    = 5'd1;
        rt_used    = 1'b0;
        issue_dest = 5'd5;
        #1;
        check("raw_issue5", {31'd0, stall}, 32'd0);
        tick();
        rs_addr    = 5'd5;
        issue_dest = 5'd6;
        #1;
        check("raw_stall_a", {31'd0, stall}, 32'd1);
        tick();
        check("raw_stall_b", {31'd0, stall}, 32'd1);
        wr_en   = 1'b1;
        wr_addr = 5'd5;
        wr_data = 32'hA5A50005;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("raw_wcyc_stall", {31'd0, stall}, 32'd0);
        check("raw_wcyc_data", rs_data, 32'hA5A50005);
        tick();
        wr_en = 1'b0;
`else
        check("raw_wcyc_stall", {31'd0, stall}, 32'd1);
        check("raw_wcyc_data", rs_data, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        check("raw_next_stall", {31'd0, stall}, 32'd0);
        check("raw_next_data", rs_data, 32'hA5A50005);
        tick();
`endif
        // Instruction with dest 6 has now issued: reg 6 must be pending
        rs_addr    = 5'd6;
        issue_dest = 5'd0;
        #1;
        check("dest6_pending", {31'd0, stall}, 32'd1);
        issue_valid = 1'b0;
        wr_en       = 1'b1;
        wr_addr     = 5'd6;
        wr_data     = 32'h00000066;
        tick();
        wr_en       = 1'b0;
        issue_valid = 1'b1;
        #1;
        check("dest6_cleared", {31'd0, stall}, 32'd0);
        check("dest6_data", rs_data, 32'h00000066);

        // 5: same-cycle write and issue of reg 9 -> set wins
        rs_addr    = 5'd0;
        rt_addr    = 5'd9;
        rt_used    = 1'b0;
        issue_dest = 5'd9;
        wr_en      = 1'b1;
        wr_addr    = 5'd9;
        wr_data    = 32'h00000099;
        #1;
        check("setclr_stall", {31'd0, stall}, 32'd0);
        tick();
        wr_en      = 1'b0;
        issue_dest = 5'd0;
        #1;
        check("r9_rt_unused", {31'd0, stall}, 32'd0);
        check("r9_data", rt_data, 32'h00000099);
        rt_used = 1'b1;
        #1;
        check("r9_rt_used", {31'd0, stall}, 32'd1);
        rt_used = 1'b0;

        // 6: pending on 3 and 4, async reset mid-stall
        issue_dest = 5'd3;
        tick();
        issue_dest = 5'd4;
        tick();
        issue_dest = 5'd0;
        rs_addr    = 5'd4;
        rt_addr    = 5'd8;
        rt_used    = 1'b1;
        #1;
        check("pend4_stall", {31'd0, stall}, 32'd1);
        rs_addr = 5'd3;
        #1;
        check("pend3_stall", {31'd0, stall}, 32'd1);
        check("pre_rst_rt", rt_data, 32'hDEADBEEF);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_rt", rt_data, 32'd0);
        rt_addr = 5'd9;
        #1;
        check("arst_r9", rt_data, 32'd0);
        #10 rst_n = 1'b1;
        tick();
        #1;
        check("post_rst_stall", {31'd0, stall}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
